ram_responder: RTL and testbench
================================

Name: ram_responder

Overview:
- Single-port RAM model that sits on the RAM side of the memory controller's `ram*` interface.
- Answers `ramREN`/`ramWEN` requests with `ramstate` and `ramload`.
- Inserts a configurable access latency so the controller's arbitration and wait logic are exercised under realistic timing.
- Used as the memory behind the controller in system-level simulation and synthesis.

Parameters:
- LAT, 2: BUSY cycles before ACCESS for each transaction; legal range 0..15.
- DEPTH, 16384: number of 32-bit words stored; must be a power of two.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- ramREN  input  1  read request, held by the requester until ACCESS.
- ramWEN  input  1  write request, held by the requester until ACCESS.
- ramaddr  input  32  byte address; word index is ramaddr[log2(DEPTH)+1:2].
- ramstore  input  32  write data; sampled on the edge that ends the ACCESS cycle.
- ramload  output  32  read data.
- ramstate  output  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3 (cpu_types_pkg ramstate_t).
- Interface decision: one clock, CLK; reset RST is synchronous and active-high.

Behaviour:
- Storage: DEPTH x 32 array, word addressed. Contents are not cleared by RST.
- Registered state:
  - cnt, width $clog2(LAT+1).
  - Captured request: op, addr.
  - Phase: IDLE or WAIT.
- Reset values (phase IDLE, cnt 0): ramstate=FREE and ramload=0 on the first cycle after RST.
- Request definition: req = ramREN | ramWEN. "Same request" means op and ramaddr both equal the captured values.
- IDLE, no req: ramstate=FREE, ramload=0.
- IDLE, req, LAT>0:
  - Capture op/addr, cnt<=1, go to WAIT.
  - ramstate=BUSY this cycle.
- WAIT, same request, cnt<LAT: ramstate=BUSY, cnt increments.
- WAIT, same request, cnt==LAT:
  - ramstate=ACCESS for exactly this one cycle; next phase IDLE.
  - A request still present next cycle is treated as a new transaction.
- Read in ACCESS: ramload = mem[word index], combinational from the current ramaddr. Outside ACCESS reads, ramload=0.
- Write in ACCESS: mem[word index] <= ramstore at the closing edge. No other cycle writes memory.
- Request changes while in WAIT (op or address differs, e.g. controller switches from iaddr to daddr):
  - Abort the old transaction; nothing is written.
  - Recapture the new request, cnt<=1, ramstate=BUSY that cycle.
- Request drops while in WAIT: abort to IDLE; ramstate=FREE that cycle.
- LAT=0:
  - ramstate=ACCESS combinationally in every cycle a legal request is present.
  - Write commits each such edge; no BUSY phase.
- ramREN and ramWEN both high: ramstate=ERROR, no memory update, phase forced to IDLE.
- RST asserted mid-transaction:
  - Phase IDLE, cnt 0; a pending write is discarded.
  - Outputs FREE/0 on the next cycle.
- Throughput: one transaction per LAT+1 cycles under back-to-back requests.

Optional Feature:
- Macro: RAM_ADDR_CHECK_EN.
- Defined:
  - ERROR is flagged when ramaddr[1:0]!=0, or when the word index is >= DEPTH (any ramaddr bit above log2(DEPTH)+1 set).
  - ramstate=ERROR that cycle, ramload=0, no write, phase IDLE.
- Not defined:
  - ramaddr[1:0] and upper bits are ignored; the address wraps modulo DEPTH words.
  - Only simultaneous REN&WEN produces ERROR.

Test Plan:
- Reset: RST=1 for 2 cycles during a pending write (WEN=1, addr 0x10, data 0xDEADBEEF), then release → ramstate=FREE, ramload=0; a later read of 0x10 returns the prior contents, not 0xDEADBEEF.
- Write/read, LAT=2:
  - WEN=1, addr 0x40, data 0x12345678 → ramstate BUSY, BUSY, ACCESS on cycles 1-3.
  - Then REN=1, addr 0x40 → BUSY, BUSY, ACCESS with ramload=0x12345678 only in the ACCESS cycle.
- Request switch: REN addr 0x100 for 1 cycle, then REN addr 0x200 → cnt restarts; ACCESS arrives 2 cycles after the switch with mem[0x200>>2] on ramload; no ACCESS for 0x100.
- Conflict: REN=1 and WEN=1, addr 0x8 → ramstate=ERROR that cycle; mem[2] unchanged on readback.
- LAT=0 build: back-to-back reads of 0x0, 0x4, 0x8 → ramstate=ACCESS every cycle, correct ramload each cycle.
- RAM_ADDR_CHECK_EN: REN addr 0x3 → ERROR. Without the macro the same read returns mem[0] after LAT BUSY cycles; addr DEPTH*4 returns mem[0].

Source files
------------

// File: rtl/ram_responder.sv
// Single-port RAM model answering ramREN/ramWEN with LAT busy cycles per access.
// Define RAM_ADDR_CHECK_EN to flag misaligned or out-of-range addresses as ERROR.
module ram_responder #(
  parameter int LAT   = 2,
  parameter int DEPTH = 16384
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ramREN,
  input  logic        ramWEN,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output logic [1:0]  ramstate
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LAT > 0) ? $clog2(LAT + 1) : 1;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } phase_t;

  logic [31:0] mem [DEPTH];

  phase_t      phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        op_q, op_d;
  logic [31:0] addr_q, addr_d;

  logic          req;
  logic          err;
  logic          same;
  logic          access;
  logic [AW-1:0] widx;
  ramstate_t     state;

  assign req  = ramREN | ramWEN;
  assign widx = ramaddr[AW+1:2];
  assign same = (phase_q == WAIT) && (op_q == ramWEN)
             && (addr_q == ramaddr);

`ifdef RAM_ADDR_CHECK_EN
  assign err = (ramREN & ramWEN) | (ramaddr[1:0] != 2'b00)
             | (|(ramaddr >> (AW + 2)));
`else
  assign err = ramREN & ramWEN;
`endif

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    state   = FREE;
    access  = 1'b0;
    if (!req) begin
      phase_d = IDLE;
      cnt_d   = '0;
    end else if (err) begin
      state   = ERROR;
      phase_d = IDLE;
      cnt_d   = '0;
    end else if (LAT == 0) begin
      state  = ACCESS;
      access = 1'b1;
    end else if (same && cnt_q == CW'(LAT)) begin
      state   = ACCESS;
      access  = 1'b1;
      phase_d = IDLE;
      cnt_d   = '0;
    end else if (same) begin
      state = BUSY;
      cnt_d = cnt_q + CW'(1);
    end else begin
      // new transaction, or a changed request that aborts the old one
      state   = BUSY;
      phase_d = WAIT;
      cnt_d   = CW'(1);
      op_d    = ramWEN;
      addr_d  = ramaddr;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      phase_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (access && ramWEN && !RST) begin
      mem[widx] <= ramstore;
    end
  end

  assign ramstate = state;
  assign ramload  = (access && !ramWEN) ? mem[widx] : 32'd0;

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder with a transaction-level reference model.
// Honours RAM_ADDR_CHECK_EN for the misaligned/out-of-range cases.
module tb_ram_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 16384;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [1:0] S_FREE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_ACC  = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ramREN = 1'b0;
  logic        ramWEN = 1'b0;
  logic [31:0] ramaddr = '0;
  logic [31:0] ramstore = '0;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  int n_checks = 0;
  int n_errors = 0;

  ram_responder #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a request held unchanged for LAT+1 consecutive
  // cycles gets ACCESS on the last of them; the count then restarts.
  logic [31:0] mmem [int];
  int          run = 0;
  logic        p_w = 1'b0;
  logic [31:0] p_a = '0;

  always @(negedge CLK) begin
    logic        m_err;
    logic [1:0]  e_st;
    logic [31:0] e_ld;
    logic        known;
    int          idx;
    if (RST) begin
      run = 0;
    end else begin
      m_err = ramREN & ramWEN;
`ifdef RAM_ADDR_CHECK_EN
      if (ramaddr[1:0] != 2'b00 || (ramaddr >> (AW + 2)) != 0)
        m_err = 1'b1;
`endif
      idx   = int'((ramaddr >> 2) % DEPTH);
      e_st  = S_FREE;
      e_ld  = '0;
      known = 1'b1;
      if (!(ramREN | ramWEN)) begin
        run = 0;
      end else if (m_err) begin
        e_st = S_ERR;
        run  = 0;
      end else begin
        if (run > 0 && p_w == ramWEN && p_a == ramaddr) run++;
        else run = 1;
        p_w = ramWEN;
        p_a = ramaddr;
        if (run == LAT + 1) begin
          e_st = S_ACC;
          run  = 0;
          if (ramWEN) mmem[idx] = ramstore;
          else if (mmem.exists(idx)) e_ld = mmem[idx];
          else known = 1'b0;
        end else begin
          e_st = S_BUSY;
        end
      end
      chk("model_state", {30'd0, ramstate}, {30'd0, e_st});
      if (known) chk("model_load", ramload, e_ld);
    end
  end

  task automatic cyc(input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d);
    @(posedge CLK);
    #1;
    ramREN   = r;
    ramWEN   = w;
    ramaddr  = a;
    ramstore = d;
    @(negedge CLK);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i <= LAT; i++) cyc(1'b0, 1'b1, a, d);
    cyc(1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    cyc(1'b0, 1'b0, '0, '0);
    cyc(1'b0, 1'b0, '0, '0);
    RST = 1'b0;
    cyc(1'b0, 1'b0, '0, '0);
    chk("reset_state", {30'd0, ramstate}, {30'd0, S_FREE});
    chk("reset_load", ramload, 32'd0);

    wr(32'h10, 32'hA5A5A5A5);
    wr(32'h44, 32'h0);
    wr(32'h200, 32'hCAFEF00D);
    wr(32'h8, 32'h11112222);
    wr(32'h0, 32'h0BADC0DE);
    wr(32'h4, 32'h44444444);

    // reset lands in the middle of a pending write
    cyc(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    @(posedge CLK); #1; RST = 1'b1;
    @(negedge CLK);
    cyc(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    @(posedge CLK); #1;
    RST = 1'b0; ramWEN = 1'b0; ramaddr = '0; ramstore = '0;
    @(negedge CLK);
    chk("post_rst_state", {30'd0, ramstate}, {30'd0, S_FREE});
    chk("post_rst_load", ramload, 32'd0);
    cyc(1'b1, 1'b0, 32'h10, '0);
    cyc(1'b1, 1'b0, 32'h10, '0);
    cyc(1'b1, 1'b0, 32'h10, '0);
    chk("rst_keep_state", {30'd0, ramstate}, {30'd0, S_ACC});
    chk("rst_keep_data", ramload, 32'hA5A5A5A5);
    cyc(1'b0, 1'b0, '0, '0);

    cyc(1'b0, 1'b1, 32'h40, 32'h12345678);
    chk("wr_c1", {30'd0, ramstate}, {30'd0, S_BUSY});
    cyc(1'b0, 1'b1, 32'h40, 32'h12345678);
    chk("wr_c2", {30'd0, ramstate}, {30'd0, S_BUSY});
    cyc(1'b0, 1'b1, 32'h40, 32'h12345678);
    chk("wr_c3", {30'd0, ramstate}, {30'd0, S_ACC});
    cyc(1'b1, 1'b0, 32'h40, '0);
    chk("rd_c1_load", ramload, 32'd0);
    cyc(1'b1, 1'b0, 32'h40, '0);
    chk("rd_c2_state", {30'd0, ramstate}, {30'd0, S_BUSY});
    cyc(1'b1, 1'b0, 32'h40, '0);
    chk("rd_c3_state", {30'd0, ramstate}, {30'd0, S_ACC});
    chk("rd_c3_load", ramload, 32'h12345678);
    cyc(1'b0, 1'b0, '0, '0);

    cyc(1'b1, 1'b0, 32'h100, '0);
    cyc(1'b1, 1'b0, 32'h200, '0);
    chk("sw_c0", {30'd0, ramstate}, {30'd0, S_BUSY});
    cyc(1'b1, 1'b0, 32'h200, '0);
    chk("sw_c1", {30'd0, ramstate}, {30'd0, S_BUSY});
    cyc(1'b1, 1'b0, 32'h200, '0);
    chk("sw_acc", {30'd0, ramstate}, {30'd0, S_ACC});
    chk("sw_load", ramload, 32'hCAFEF00D);
    cyc(1'b0, 1'b0, '0, '0);

    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 32'h8, 32'hFFFFFFFF);
      chk("conflict_state", {30'd0, ramstate}, {30'd0, S_ERR});
    end
    cyc(1'b0, 1'b0, '0, '0);
    for (int i = 0; i <= LAT; i++) cyc(1'b1, 1'b0, 32'h8, '0);
    chk("conflict_keep", ramload, 32'h11112222);
    cyc(1'b0, 1'b0, '0, '0);

    // write dropped while waiting must not land
    cyc(1'b0, 1'b1, 32'h44, 32'h77);
    cyc(1'b0, 1'b0, '0, '0);
    chk("drop_state", {30'd0, ramstate}, {30'd0, S_FREE});
    for (int i = 0; i <= LAT; i++) cyc(1'b1, 1'b0, 32'h44, '0);
    chk("drop_keep", ramload, 32'h0);
    cyc(1'b0, 1'b0, '0, '0);

    cyc(1'b1, 1'b0, 32'h3, '0);
`ifdef RAM_ADDR_CHECK_EN
    chk("misalign_err", {30'd0, ramstate}, {30'd0, S_ERR});
    cyc(1'b1, 1'b0, 32'h10000, '0);
    chk("range_err", {30'd0, ramstate}, {30'd0, S_ERR});
`else
    cyc(1'b1, 1'b0, 32'h3, '0);
    cyc(1'b1, 1'b0, 32'h3, '0);
    chk("misalign_load", ramload, 32'h0BADC0DE);
    cyc(1'b0, 1'b0, '0, '0);
    for (int i = 0; i <= LAT; i++) cyc(1'b1, 1'b0, 32'h10000, '0);
    chk("wrap_load", ramload, 32'h0BADC0DE);
`endif
    cyc(1'b0, 1'b0, '0, '0);

    // back-to-back reads
    for (int k = 0; k < 3; k++)
      for (int i = 0; i <= LAT; i++)
        cyc(1'b1, 1'b0, 32'(k * 4), '0);
    chk("b2b_last", ramload, 32'h11112222);
    cyc(1'b0, 1'b0, '0, '0);
    cyc(1'b0, 1'b0, '0, '0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
